// File: rtl/lc3b_pkg.sv
// lc3b_pkg: constants, sequencer state encoding and the control-store
// address mapping shared by the LC-3b decode stage.
// Optional feature macro: DECODE_ILLEGAL_DETECT_EN (adds the ILLEGAL state).
package lc3b_pkg;

   // Width of one control-store word
   localparam int CS_WIDTH = 23;

   // Opcodes that the decode stage cares about by name
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_JSR   = 4'b0100;
   localparam logic [3:0] OP_RTI   = 4'b1000;
   localparam logic [3:0] OP_RSV_A = 4'b1010;
   localparam logic [3:0] OP_RSV_B = 4'b1011;

   // Decode-sequencer states; ILLEGAL exists only when detection is built in
   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
`ifdef DECODE_ILLEGAL_DETECT_EN
      ILLEGAL = 2'b10,
`endif
      FULL    = 2'b01
   } seqState_e;

   // Control-store address: opcode plus the two mode bits that split
   // register/immediate and JSR/JSRR forms
   function automatic logic [5:0] mapCsAddr(input logic [3:0] opcode,
                                            input logic       bit11,
                                            input logic       bit5);
      return {opcode, bit11, bit5};
   endfunction

endpackage

// File: rtl/decode_sequencer.sv
// decode_sequencer: one-entry decode stage that pairs each accepted
// instruction with its control word read from an external synchronous ROM.
// Optional feature macro: DECODE_ILLEGAL_DETECT_EN -- an all-zero control
// word in FULL traps the stage in ILLEGAL until flushed.
module decode_sequencer
   import lc3b_pkg::*;
#(
   parameter int CS_W  = CS_WIDTH,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ir_in,
   input  logic             ir_valid,
   output logic             ir_ready,
   output logic [5:0]       cs_addr,
   input  logic [CS_W-1:0]  cs_bits,
   input  logic             flush,
   output logic             de_valid,
   input  logic             de_ready,
   output logic [15:0]      de_ir,
   output logic [CS_W-1:0]  de_cs,
   output logic [CNT_W-1:0] issue_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             illegal_op
);

   seqState_e        state_q, state_d;
   logic [15:0]      deIr_q, deIr_d;
   logic [CNT_W-1:0] issueCnt_q, issueCnt_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic             accept;
   logic             illegalHit;

`ifdef DECODE_ILLEGAL_DETECT_EN
   logic             illegal_q, illegal_d;

   assign illegalHit = (state_q == FULL) && (cs_bits == '0);
   assign illegal_op = illegal_q;
`else
   assign illegalHit = 1'b0;
   assign illegal_op = 1'b0;
`endif

   assign de_ir     = deIr_q;
   assign de_cs     = cs_bits;
   assign issue_cnt = issueCnt_q;
   assign stall_cnt = stallCnt_q;

   // Handshake and ROM address: new word on accept, otherwise re-read the held one
   always_comb begin
      ir_ready = !rst && !flush && (state_q == EMPTY || de_ready);
`ifdef DECODE_ILLEGAL_DETECT_EN
      if (state_q == ILLEGAL) ir_ready = 1'b0;
`endif
      accept   = ir_valid && ir_ready;
      de_valid = (state_q == FULL) && !illegalHit;
      if (accept) cs_addr = mapCsAddr(ir_in[15:12], ir_in[11], ir_in[5]);
      else        cs_addr = mapCsAddr(deIr_q[15:12], deIr_q[11], deIr_q[5]);
   end

   // Next-state logic; flush always returns the stage to EMPTY
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (de_ready && !accept) state_d = EMPTY;
`ifdef DECODE_ILLEGAL_DETECT_EN
            if (illegalHit) state_d = ILLEGAL;
`endif
         end
`ifdef DECODE_ILLEGAL_DETECT_EN
         ILLEGAL: begin
            state_d = ILLEGAL;
         end
`endif
         default: begin
            state_d = EMPTY;
         end
      endcase
      if (flush) state_d = EMPTY;
   end

   // Held instruction and the issue/stall counters (frozen during flush)
   always_comb begin
      deIr_d     = accept ? ir_in : deIr_q;
      issueCnt_d = issueCnt_q;
      stallCnt_d = stallCnt_q;
      if (!flush && de_valid) begin
         if (de_ready) issueCnt_d = issueCnt_q + CNT_W'(1);
         else          stallCnt_d = stallCnt_q + CNT_W'(1);
      end
`ifdef DECODE_ILLEGAL_DETECT_EN
      illegal_d = illegal_q;
      if (illegalHit) illegal_d = 1'b1;
      if (flush)      illegal_d = 1'b0;
`endif
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         deIr_q     <= '0;
         issueCnt_q <= '0;
         stallCnt_q <= '0;
`ifdef DECODE_ILLEGAL_DETECT_EN
         illegal_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         deIr_q     <= deIr_d;
         issueCnt_q <= issueCnt_d;
         stallCnt_q <= stallCnt_d;
`ifdef DECODE_ILLEGAL_DETECT_EN
         illegal_q  <= illegal_d;
`endif
      end
   end

endmodule
